// File: rtl/adder_share_pkg.sv
// adder_share_pkg: shared types, widths and helpers for the adder-sharing arbiter.
//   state_e      : arbiter FSM states
//   ADD_W/SUM_W  : operand width and sum width (operand width plus carry)
//   pack_add_in  : interleaves two operands onto the adder input bus
package adder_share_pkg;

   localparam int unsigned ADD_W   = 12;
   localparam int unsigned SUM_W   = ADD_W + 1;
   localparam int unsigned ADDIN_W = 2 * ADD_W;
   localparam int unsigned CNT_W   = 8;
   localparam int unsigned CHK_W   = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   // Adder netlist expects a[k] on bit 2k and b[k] on bit 2k+1.
   function automatic logic [ADDIN_W-1:0] pack_add_in(input logic [ADD_W-1:0] a,
                                                      input logic [ADD_W-1:0] b);
      logic [ADDIN_W-1:0] r;
      r = '0;
      for (int unsigned k = 0; k < ADD_W; k++) begin
         r[2*k]   = a[k];
         r[2*k+1] = b[k];
      end
      return r;
   endfunction

endpackage

// File: rtl/adder_share_arb_rr_pick.sv
// rr_pick: combinational round-robin first-set search.
//   cand_i   : eligible-and-valid mask
//   ptr_i    : index the search starts from (wraps past N-1 to 0)
//   onehot_o : one-hot winner, zero when nothing is set
//   idx_o    : binary winner index, zero when nothing is set
//   any_o    : a winner exists
module rr_pick #(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = 3
) (
   input  logic [N-1:0]  cand_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  onehot_o,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);

   // Walk offsets 0..N-1 from the pointer; the first set candidate wins.
   always_comb begin
      int unsigned pos;
      logic        found;
      onehot_o = '0;
      idx_o    = '0;
      found    = 1'b0;
      pos      = 0;
      for (int unsigned k = 0; k < N; k++) begin
         pos = 32'(ptr_i) + k;
         if (pos >= N) pos = pos - N;
         for (int unsigned i = 0; i < N; i++) begin
            if (!found && (pos == i) && cand_i[i]) begin
               found       = 1'b1;
               onehot_o[i] = 1'b1;
               idx_o       = IW'(i);
            end
         end
      end
      any_o = found;
   end

endmodule

// File: rtl/adder_share_arb.sv
// adder_share_arb: shares one external combinational 12-bit adder among NREQ
// requesters with round-robin arbitration and optional burst lock.
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/req_ready   : per-requester handshake (req_ready one-hot or zero)
//   req_lock              : keep the grant after this beat
//   req_a/req_b           : packed operands, requester i at [12i+11:12i]
//   add_in/add_out        : to/from the external adder netlist
//   rsp_valid/rsp_ready   : shared response handshake
//   rsp_sum/rsp_id        : registered sum and producing requester
//   busy                  : FSM not idle
// Build option ADD_SELFCHECK_EN adds chk_err (sticky reference-adder mismatch)
// and an internal saturating mismatch counter.
module adder_share_arb
   import adder_share_pkg::*;
#(
   parameter int unsigned NREQ     = 4,
   parameter int unsigned LOCK_MAX = 8,
   parameter int unsigned IDW      = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [NREQ-1:0]         req_lock,
   input  logic [NREQ*ADD_W-1:0]   req_a,
   input  logic [NREQ*ADD_W-1:0]   req_b,
   output logic [ADDIN_W-1:0]      add_in,
   input  logic [SUM_W-1:0]        add_out,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [SUM_W-1:0]        rsp_sum,
   output logic [IDW-1:0]          rsp_id,
   output logic                    busy
`ifdef ADD_SELFCHECK_EN
   ,output logic                   chk_err
`endif
);

   state_e             state_q, state_d;
   logic [ADD_W-1:0]   op_a_q, op_a_d;
   logic [ADD_W-1:0]   op_b_q, op_b_d;
   logic [IDW-1:0]     id_q, id_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic [SUM_W-1:0]   rsp_sum_q, rsp_sum_d;
   logic [IDW-1:0]     rsp_id_q, rsp_id_d;
   logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
   logic [IDW-1:0]     owner_q, owner_d;
   logic               owner_vld_q, owner_vld_d;

   logic [NREQ-1:0]    elig;
   logic [NREQ-1:0]    cand;
   logic [NREQ-1:0]    pick_onehot;
   logic [IDW-1:0]     pick_idx;
   logic               pick_any;
   logic               grant_en;
   logic               accept;
   logic               lock_sel;
   logic [IDW-1:0]     pick_next;
   logic [CNT_W-1:0]   cnt_inc;
   logic [ADD_W-1:0]   sel_a;
   logic [ADD_W-1:0]   sel_b;

   // An existing owner excludes everyone else, even while it is not requesting.
   assign elig = owner_vld_q ? (NREQ'(1) << owner_q) : '1;
   assign cand = req_valid & elig;

   rr_pick #(
      .N  (NREQ),
      .IW (IDW)
   ) u_pick (
      .cand_i   (cand),
      .ptr_i    (rr_ptr_q),
      .onehot_o (pick_onehot),
      .idx_o    (pick_idx),
      .any_o    (pick_any)
   );

   // Grant logic runs in IDLE and, for back-to-back, when RESP is being drained.
   assign grant_en  = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);
   assign accept    = grant_en && pick_any;
   assign req_ready = grant_en ? pick_onehot : '0;

   assign lock_sel  = |(req_lock & pick_onehot);
   assign pick_next = (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + IDW'(1);
   assign cnt_inc   = lock_cnt_q + CNT_W'(1);

   // Operand mux for the winning requester.
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (pick_onehot[i]) begin
            sel_a = req_a[i*ADD_W +: ADD_W];
            sel_b = req_b[i*ADD_W +: ADD_W];
         end
      end
   end

   // Next-state, datapath capture and arbitration bookkeeping.
   always_comb begin
      state_d     = state_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      id_d        = id_q;
      rsp_valid_d = rsp_valid_q;
      rsp_sum_d   = rsp_sum_q;
      rsp_id_d    = rsp_id_q;
      rr_ptr_d    = rr_ptr_q;
      lock_cnt_d  = lock_cnt_q;
      owner_d     = owner_q;
      owner_vld_d = owner_vld_q;

      case (state_q)
         IDLE: begin
            if (accept) state_d = EXEC;
         end
         EXEC: begin
            rsp_sum_d   = add_out;
            rsp_valid_d = 1'b1;
            rsp_id_d    = id_q;
            state_d     = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = accept ? EXEC : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (accept) begin
         op_a_d = sel_a;
         op_b_d = sel_b;
         id_d   = pick_idx;
         if (lock_sel) begin
            // Forced release once the burst reaches its limit.
            if (cnt_inc >= CNT_W'(LOCK_MAX)) begin
               owner_vld_d = 1'b0;
               lock_cnt_d  = '0;
               rr_ptr_d    = pick_next;
            end else begin
               owner_vld_d = 1'b1;
               owner_d     = pick_idx;
               lock_cnt_d  = cnt_inc;
            end
         end else begin
            owner_vld_d = 1'b0;
            lock_cnt_d  = '0;
            rr_ptr_d    = pick_next;
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         op_a_q      <= '0;
         op_b_q      <= '0;
         id_q        <= '0;
         rsp_valid_q <= 1'b0;
         rsp_sum_q   <= '0;
         rsp_id_q    <= '0;
         rr_ptr_q    <= '0;
         lock_cnt_q  <= '0;
         owner_q     <= '0;
         owner_vld_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         id_q        <= id_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_sum_q   <= rsp_sum_d;
         rsp_id_q    <= rsp_id_d;
         rr_ptr_q    <= rr_ptr_d;
         lock_cnt_q  <= lock_cnt_d;
         owner_q     <= owner_d;
         owner_vld_q <= owner_vld_d;
      end
   end

   assign add_in    = pack_add_in(op_a_q, op_b_q);
   assign rsp_valid = rsp_valid_q;
   assign rsp_sum   = rsp_sum_q;
   assign rsp_id    = rsp_id_q;
   assign busy      = (state_q != IDLE);

`ifdef ADD_SELFCHECK_EN
   logic [SUM_W-1:0] ref_sum;
   logic             mismatch;
   logic             chk_err_q, chk_err_d;
   logic [CHK_W-1:0] chk_cnt_q, chk_cnt_d;

   // Behavioural reference for the external adder, compared only in EXEC.
   assign ref_sum  = SUM_W'(op_a_q) + SUM_W'(op_b_q);
   assign mismatch = (state_q == EXEC) && (add_out != ref_sum);

   always_comb begin
      chk_err_d = chk_err_q | mismatch;
      chk_cnt_d = chk_cnt_q;
      if (mismatch && (chk_cnt_q != '1)) chk_cnt_d = chk_cnt_q + CHK_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chk_err_q <= 1'b0;
         chk_cnt_q <= '0;
      end else begin
         chk_err_q <= chk_err_d;
         chk_cnt_q <= chk_cnt_d;
      end
   end

   assign chk_err = chk_err_q;
`endif

endmodule
